atm_keypad_entry: RTL and testbench

//  Scans a 4x4 matrix keypad, debounces it and turns key presses into the controller's input

---
 rtl/atm_keypad_entry.sv | 253 +++++++++++++++++++++++++
 tb/tb_atm_keypad_entry.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: 4x4 keypad scanner, debouncer and PIN/amount entry front end.
// Optional beep output is enabled with `define ATM_KEYPAD_BEEP_EN.
module atm_keypad_entry #(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MAX_DIGITS     = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  kp_col_n,
  output logic [3:0]  kp_row_n,
  input  logic        amount_mode,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic        add_digit,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        entry_err
`ifdef ATM_KEYPAD_BEEP_EN
  ,
  output logic        beep
`endif
);

  localparam int DW  = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEBOUNCE_SCANS - 1);
  localparam logic [3:0]     MAXD     = 4'(MAX_DIGITS);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

  logic [DW-1:0]  div_q, div_d;
  logic [1:0]     row_q, row_d;
  logic [1:0]     hits_q, hits_d;
  logic [3:0]     code_q, code_d;
  state_t         state_q, state_d;
  logic [3:0]     cand_q, cand_d;
  logic [DBW-1:0] deb_q, deb_d;
  logic [31:0]    acc_q, acc_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic [3:0]     digito_q, digito_d;
  logic           dstb_q, dstb_d;
  logic           add_q, add_d;
  logic [31:0]    monto_q, monto_d;
  logic           mstb_q, mstb_d;
  logic           err_q, err_d;

  logic [3:0]  col_low;
  logic [2:0]  col_cnt;
  logic [1:0]  col_idx;
  logic [2:0]  sum;
  logic [1:0]  hits_all;
  logic        slot_end, scan_done, scan_any, scan_one;
  logic [3:0]  scan_key;
  logic        fire, is_digit, is_enter, is_clear, mode_edge;
  logic [3:0]  dval;
  logic [35:0] acc_next;

  assign kp_row_n   = ~(4'b0001 << row_q);
  assign digito     = digito_q;
  assign digito_stb = dstb_q;
  assign add_digit  = add_q;
  assign monto      = monto_q;
  assign monto_stb  = mstb_q;
  assign entry_err  = err_q;

  // Row scanning and per-scan key accumulation (0, 1 or multiple keys).
  always_comb begin
    col_low = ~kp_col_n;
    col_cnt = 3'(col_low[0]) + 3'(col_low[1])
            + 3'(col_low[2]) + 3'(col_low[3]);
    col_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (col_low[i]) col_idx = 2'(i);
    sum      = {1'b0, hits_q} + col_cnt;
    hits_all = (sum > 3'd1) ? 2'd2 : sum[1:0];
    slot_end  = (div_q == DIV_LAST);
    scan_done = slot_end && (row_q == 2'd3);
    div_d  = slot_end ? '0 : div_q + 1'b1;
    row_d  = slot_end ? row_q + 2'd1 : row_q;
    hits_d = hits_q;
    code_d = code_q;
    if (slot_end) begin
      hits_d = (row_q == 2'd3) ? 2'd0 : hits_all;
      if (col_cnt == 3'd1) code_d = {row_q, col_idx};
    end
    scan_any = (hits_all != 2'd0);
    scan_one = (hits_all == 2'd1);
    scan_key = (col_cnt == 3'd1) ? {row_q, col_idx} : code_q;
  end

  // Debounce FSM, key decode and entry actions.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    deb_d    = deb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    digito_d = digito_q;
    monto_d  = monto_q;
    dstb_d   = 1'b0;
    add_d    = 1'b0;
    mstb_d   = 1'b0;
    err_d    = 1'b0;
    fire     = 1'b0;
    mode_d   = amount_mode;
    mode_edge = (amount_mode != mode_q);

    if (scan_done) begin
      unique case (state_q)
        IDLE: if (scan_one) begin
          state_d = DEB_PRESS;
          cand_d  = scan_key;
          deb_d   = '0;
        end
        DEB_PRESS:
          if (scan_one && scan_key == cand_q) begin
            if (deb_q == DEB_LAST) begin
              state_d = HELD;
              fire    = 1'b1;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        HELD: if (!scan_any) begin
          state_d = DEB_REL;
          deb_d   = '0;
        end
        DEB_REL:
          if (scan_any) begin
            state_d = HELD;
          end else if (deb_q == DEB_LAST) begin
            state_d = IDLE;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        default: state_d = IDLE;
      endcase
    end

    is_digit = 1'b1;
    is_enter = 1'b0;
    is_clear = 1'b0;
    dval     = 4'd0;
    case (cand_q)
      4'h0: dval = 4'd1;
      4'h1: dval = 4'd2;
      4'h2: dval = 4'd3;
      4'h4: dval = 4'd4;
      4'h5: dval = 4'd5;
      4'h6: dval = 4'd6;
      4'h8: dval = 4'd7;
      4'h9: dval = 4'd8;
      4'hA: dval = 4'd9;
      4'hD: dval = 4'd0;
      4'h3: begin is_digit = 1'b0; is_enter = 1'b1; end
      4'h7: begin is_digit = 1'b0; is_clear = 1'b1; end
      default: is_digit = 1'b0;
    endcase
    acc_next = {4'b0, acc_q} * 36'd10 + {32'b0, dval};

    if (mode_edge) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (fire) begin
      if (is_digit && !amount_mode) begin
        digito_d = dval;
        dstb_d   = 1'b1;
        add_d    = 1'b1;
      end else if (is_digit) begin
        if (cnt_q < MAXD && acc_next[35:32] == 4'd0) begin
          acc_d    = acc_next[31:0];
          cnt_d    = cnt_q + 4'd1;
          digito_d = dval;
          dstb_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (is_enter && amount_mode && cnt_q != 4'd0) begin
        monto_d = acc_q;
        mstb_d  = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else if (is_clear) begin
        acc_d = '0;
        cnt_d = '0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      row_q    <= 2'd0;
      hits_q   <= 2'd0;
      code_q   <= 4'd0;
      state_q  <= IDLE;
      cand_q   <= 4'd0;
      deb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= 4'd0;
      mode_q   <= 1'b0;
      digito_q <= 4'd0;
      dstb_q   <= 1'b0;
      add_q    <= 1'b0;
      monto_q  <= '0;
      mstb_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      row_q    <= row_d;
      hits_q   <= hits_d;
      code_q   <= code_d;
      state_q  <= state_d;
      cand_q   <= cand_d;
      deb_q    <= deb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      digito_q <= digito_d;
      dstb_q   <= dstb_d;
      add_q    <= add_d;
      monto_q  <= monto_d;
      mstb_q   <= mstb_d;
      err_q    <= err_d;
    end
  end

`ifdef ATM_KEYPAD_BEEP_EN
  localparam int BW = $clog2(4 * SCAN_DIV + 1);
  logic [BW-1:0] beep_q, beep_d;
  assign beep = (beep_q != '0);

  // Beep duration counter, restarted by every strobe.
  always_comb begin
    beep_d = beep_q;
    if (dstb_d || mstb_d || err_d) beep_d = BW'(4 * SCAN_DIV);
    else if (beep_q != '0) beep_d = beep_q - 1'b1;
  end

  // Beep counter register.
  always_ff @(posedge clk) begin
    if (rst) beep_q <= '0;
    else     beep_q <= beep_d;
  end
`endif

endmodule

// File: tb/tb_atm_keypad_entry.sv
// tb_atm_keypad_entry: directed bench with a keypad matrix model.
// Runs with SCAN_DIV=4, DEBOUNCE_SCANS=2 (one full scan = 16 clk).
module tb_atm_keypad_entry;

  localparam int SCAN = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  kp_col_n;
  logic [3:0]  kp_row_n;
  logic        amount_mode = 1'b0;
  logic [3:0]  digito;
  logic        digito_stb, add_digit, monto_stb, entry_err;
  logic [31:0] monto;

  logic        key_on = 1'b0;
  logic [3:0]  key_code = 4'h0;

  int n_chk = 0, n_pass = 0;
  int n_dig = 0, n_add = 0, n_mon = 0, n_err = 0, n_ovl = 0, n_addbad = 0;
  int e_dig = 0, e_mon = 0, e_err = 0;

  atm_keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .MAX_DIGITS(9)) dut (
    .clk(clk), .rst(rst), .kp_col_n(kp_col_n), .kp_row_n(kp_row_n),
    .amount_mode(amount_mode), .digito(digito), .digito_stb(digito_stb),
    .add_digit(add_digit), .monto(monto), .monto_stb(monto_stb),
    .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  assign kp_col_n = (key_on && kp_row_n[key_code[3:2]] == 1'b0)
                  ? ~(4'b0001 << key_code[1:0]) : 4'hF;

  always @(negedge clk) begin
    if (digito_stb) n_dig++;
    if (add_digit) n_add++;
    if (monto_stb) n_mon++;
    if (entry_err) n_err++;
    if (int'(digito_stb) + int'(monto_stb) + int'(entry_err) > 1) n_ovl++;
    if (add_digit && !digito_stb) n_addbad++;
  end

  function automatic logic [3:0] kc(input int d);
    case (d)
      1: kc = 4'h0; 2: kc = 4'h1; 3: kc = 4'h2;
      4: kc = 4'h4; 5: kc = 4'h5; 6: kc = 4'h6;
      7: kc = 4'h8; 8: kc = 4'h9; 9: kc = 4'hA;
      default: kc = 4'hD;
    endcase
  endfunction

  task automatic press(input logic [3:0] code, input int scans);
    @(negedge clk);
    key_code = code;
    key_on = 1'b1;
    repeat (scans * SCAN) @(negedge clk);
    key_on = 1'b0;
    repeat (5 * SCAN) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] exp_row [5];
    exp_row[0] = 4'hE; exp_row[1] = 4'hD; exp_row[2] = 4'hB;
    exp_row[3] = 4'h7; exp_row[4] = 4'hE;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({digito_stb, add_digit, monto_stb, entry_err} !== 4'b0)
      $display("FAIL reset_strobes: got %b want 0000",
               {digito_stb, add_digit, monto_stb, entry_err});
    else n_pass++;
    n_chk++;
    if (digito !== 4'd0) $display("FAIL reset_digito: got %0d want 0", digito);
    else n_pass++;
    n_chk++;
    if (monto !== 32'd0) $display("FAIL reset_monto: got %0d want 0", monto);
    else n_pass++;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) repeat (4) @(negedge clk);
      n_chk++;
      if (kp_row_n !== exp_row[k])
        $display("FAIL scan_row%0d: got %h want %h", k, kp_row_n, exp_row[k]);
      else n_pass++;
    end
    repeat (3 * SCAN) @(negedge clk);
    n_chk++;
    if (n_dig + n_mon + n_err !== 0)
      $display("FAIL idle_strobes: got %0d want 0", n_dig + n_mon + n_err);
    else n_pass++;
  endtask

  task automatic test_pin;
    int seq [4];
    seq[0] = 4; seq[1] = 7; seq[2] = 5; seq[3] = 6;
    amount_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      press(kc(seq[i]), 3);
      e_dig++;
      n_chk++;
      if (n_dig !== e_dig || n_add !== e_dig)
        $display("FAIL pin_stb%0d: got dig=%0d add=%0d want %0d",
                 i, n_dig, n_add, e_dig);
      else n_pass++;
      n_chk++;
      if (digito !== 4'(seq[i]))
        $display("FAIL pin_digit%0d: got %0d want %0d", i, digito, seq[i]);
      else n_pass++;
    end
    n_chk++;
    if (n_mon !== 0) $display("FAIL pin_monto_stb: got %0d want 0", n_mon);
    else n_pass++;
  endtask

  task automatic test_amount;
    int seq [4];
    int add0;
    seq[0] = 4; seq[1] = 5; seq[2] = 0; seq[3] = 0;
    amount_mode = 1'b1;
    repeat (4) @(negedge clk);
    add0 = n_add;
    for (int i = 0; i < 4; i++) press(kc(seq[i]), 3);
    e_dig += 4;
    n_chk++;
    if (n_dig !== e_dig || n_add !== add0)
      $display("FAIL amt_digits: got dig=%0d add=%0d want dig=%0d add=%0d",
               n_dig, n_add, e_dig, add0);
    else n_pass++;
    press(4'h3, 3);
    e_mon++;
    n_chk++;
    if (n_mon !== e_mon || monto !== 32'd4500)
      $display("FAIL amt_enter: got stb=%0d monto=%0d want stb=%0d monto=4500",
               n_mon, monto, e_mon);
    else n_pass++;
    press(4'h3, 3);
    n_chk++;
    if (n_mon !== e_mon)
      $display("FAIL amt_enter_empty: got stb=%0d want %0d", n_mon, e_mon);
    else n_pass++;
  endtask

  task automatic test_debounce;
    press(kc(9), 1);
    n_chk++;
    if (n_dig !== e_dig)
      $display("FAIL glitch: got dig=%0d want %0d", n_dig, e_dig);
    else n_pass++;
    press(kc(9), 50);
    e_dig++;
    n_chk++;
    if (n_dig !== e_dig || digito !== 4'd9)
      $display("FAIL long_hold: got dig=%0d digito=%0d want dig=%0d digito=9",
               n_dig, digito, e_dig);
    else n_pass++;
    press(4'h7, 3);
    press(4'h3, 3);
    n_chk++;
    if (n_mon !== e_mon)
      $display("FAIL clear_enter: got stb=%0d want %0d", n_mon, e_mon);
    else n_pass++;
  endtask

  task automatic test_overflow;
    int seq [9];
    seq[0] = 4; seq[1] = 2; seq[2] = 9; seq[3] = 4; seq[4] = 9;
    seq[5] = 6; seq[6] = 7; seq[7] = 2; seq[8] = 9;
    for (int i = 0; i < 9; i++) press(kc(seq[i]), 3);
    e_dig += 9;
    n_chk++;
    if (n_dig !== e_dig || n_err !== e_err)
      $display("FAIL ovf_fill: got dig=%0d err=%0d want dig=%0d err=%0d",
               n_dig, n_err, e_dig, e_err);
    else n_pass++;
    press(kc(6), 3);
    e_err++;
    n_chk++;
    if (n_err !== e_err || n_dig !== e_dig || digito !== 4'd9)
      $display("FAIL ovf_err: got err=%0d dig=%0d digito=%0d want err=%0d dig=%0d digito=9",
               n_err, n_dig, digito, e_err, e_dig);
    else n_pass++;
    press(kc(5), 3);
    e_err++;
    n_chk++;
    if (n_err !== e_err || n_dig !== e_dig)
      $display("FAIL maxdig_err: got err=%0d dig=%0d want err=%0d dig=%0d",
               n_err, n_dig, e_err, e_dig);
    else n_pass++;
    press(4'h3, 3);
    e_mon++;
    n_chk++;
    if (n_mon !== e_mon || monto !== 32'd429496729)
      $display("FAIL ovf_acc: got stb=%0d monto=%0d want stb=%0d monto=429496729",
               n_mon, monto, e_mon);
    else n_pass++;
  endtask

  task automatic test_mode_clear;
    press(kc(1), 3);
    press(kc(2), 3);
    e_dig += 2;
    amount_mode = 1'b0;
    repeat (5) @(negedge clk);
    amount_mode = 1'b1;
    repeat (5) @(negedge clk);
    press(4'h3, 3);
    n_chk++;
    if (n_mon !== e_mon || n_dig !== e_dig)
      $display("FAIL mode_clear: got stb=%0d dig=%0d want stb=%0d dig=%0d",
               n_mon, n_dig, e_mon, e_dig);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    press(kc(1), 3);
    press(kc(2), 3);
    e_dig += 2;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    press(4'h3, 3);
    n_chk++;
    if (n_mon !== e_mon || monto !== 32'd0)
      $display("FAIL reset_mid: got stb=%0d monto=%0d want stb=%0d monto=0",
               n_mon, monto, e_mon);
    else n_pass++;
  endtask

  task automatic test_strobe_rules;
    n_chk++;
    if (n_ovl !== 0) $display("FAIL strobe_overlap: got %0d want 0", n_ovl);
    else n_pass++;
    n_chk++;
    if (n_addbad !== 0) $display("FAIL add_digit_alone: got %0d want 0", n_addbad);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_pin;
    test_amount;
    test_debounce;
    test_overflow;
    test_mode_clear;
    test_reset_mid;
    test_strobe_rules;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
